zap_fetch_issue_fifo: RTL and testbench
=======================================

Name: zap_fetch_issue_fifo

Overview:
- Instruction holding FIFO between the fetch stage and the LDM/STM/SWP predecode sequencer. It is the producer side of the sequencer's stall handshake.
- While the sequencer expands a multi-cycle instruction it asserts i_stall_from_decode. During that time this block presents the same head entry, unchanged, with its PC and interrupt bits.
- Accepts fetched instructions while space remains, and back-pressures fetch through o_fetch_stall before overflow can occur.
- Flushes on pipeline clears, using the same priority order as the rest of the predecode stage.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- i_clk  in  1  ZAP clock.
- i_reset  in  1  reset; synchronous, active-high, on clock i_clk.
- i_instruction  in  35  fetched instruction, including extended register bits.
- i_instruction_valid  in  1  write request from fetch.
- i_pc  in  32  PC of the fetched instruction.
- i_irq  in  1  IRQ sampled with this instruction.
- i_fiq  in  1  FIQ sampled with this instruction.
- i_stall_from_decode  in  1  sequencer holding the current head.
- i_clear_from_writeback  in  1  flush from writeback.
- i_data_stall  in  1  global memory stall.
- i_clear_from_alu  in  1  flush from ALU (branch or mispredict).
- i_stall_from_shifter  in  1  shifter stall.
- i_issue_stall  in  1  issue stall.
- o_instruction  out  35  head instruction.
- o_instruction_valid  out  1  FIFO not empty.
- o_pc  out  32  head PC.
- o_irq  out  1  head IRQ bit.
- o_fiq  out  1  head FIQ bit.
- o_fetch_stall  out  1  back-pressure to fetch.
- o_overflow  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Storage: circular array of DEPTH entries, each {instruction, pc, irq, fiq}.
  - rd_ptr and wr_ptr are PTR_W bits wide and wrap modulo DEPTH.
  - count is PTR_W+1 bits wide, range 0..DEPTH.
- Outputs are driven from registers and the storage array only. There is no combinational path from any i_* data or control input to any o_* port.
- Read-out:
  - o_instruction_valid = (count != 0).
  - o_instruction, o_pc, o_irq, o_fiq = entry[rd_ptr].
  - When count == 0, these fields are forced to 0.
- Pop condition: pop = o_instruction_valid && !i_stall_from_decode && !i_data_stall && !i_stall_from_shifter && !i_issue_stall.
- Push condition: push = i_instruction_valid && (count < DEPTH).
  - The count used is the current count, so a simultaneous pop does not make room in the same cycle.
  - If i_instruction_valid && count == DEPTH, the write is dropped and o_overflow pulses high for one cycle.
- Latency: an instruction pushed in cycle N appears at the output in cycle N+1 at the earliest. There is no bypass.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- o_fetch_stall = (count >= DEPTH-1), derived from the registered count. This leaves one free slot for the beat already in flight from fetch.
- Update priority per clock edge, highest first:
  1. i_reset: rd_ptr = wr_ptr = count = 0, o_overflow = 0; storage contents don't-care.
  2. i_clear_from_writeback: same flush; any push in this cycle is discarded.
  3. i_data_stall: no pop. A push is still accepted if space exists.
  4. i_clear_from_alu: flush; any push in this cycle is discarded.
  5. Otherwise: normal push and/or pop.
- Reset values of outputs: o_instruction_valid = 0, o_instruction = 0, o_pc = 0, o_irq = 0, o_fiq = 0, o_fetch_stall = 0, o_overflow = 0.
- Interrupt bits travel with their instruction and are never merged or dropped independently.
  - A raw i_irq or i_fiq with i_instruction_valid = 0 is ignored; fetch re-presents it with a later instruction.
- Head stability: while i_stall_from_decode = 1 and no flush occurs, o_instruction, o_pc, o_irq and o_fiq remain bit-identical, even when pushes fill the FIFO.
- Reset or clear in the middle of a sequence: the head is discarded immediately. Valid deasserts in the next cycle.

Test Plan:
- Reset, then push 0xE1A00000 at PC 0x100 with irq=1. Expect valid=1, instruction=0xE1A00000, pc=0x100, irq=1 one cycle later; pop, then valid=0.
- Push 4 back-to-back instructions, no stall. Expect in-order output; o_fetch_stall high exactly when count >= 3; no overflow.
- Hold i_stall_from_decode=1 for 5 cycles with an LDM at the head while pushing 3 more. Expect the head unchanged each cycle, count reaches 4, and a 5th push asserts o_overflow for one cycle.
- At count=4 with pop and push together: push refused with o_overflow=1. At count=3 with pop and push together: count stays 3 and the pointers wrap correctly past DEPTH.
- Assert i_clear_from_alu and i_data_stall together with count=2. Expect no flush, because the data stall wins. Next cycle, i_clear_from_alu alone gives count=0 and valid=0.
- Assert i_clear_from_writeback with a simultaneous push. Expect the FIFO empty next cycle and the pushed instruction never appears on the output.

Source files
------------

// File: rtl/zap_fetch_issue_fifo.sv
// zap_fetch_issue_fifo
// Holding FIFO between instruction fetch and the LDM/STM/SWP predecode
// sequencer. The head entry stays frozen while the sequencer stalls. Fetch
// is back-pressured one entry early, so that the beat already in flight
// still has a free slot. Pipeline clears flush the FIFO, using the same
// priority order as the rest of the predecode stage.
module zap_fetch_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_issue_stall,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_fetch_stall,
  output logic        o_overflow
);

  localparam int ENTRY_W = 35 + 32 + 1 + 1;
  localparam logic [PTR_W:0] C_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] C_ALMOST  = (PTR_W + 1)'(DEPTH - 1);
  localparam logic [PTR_W:0] C_ZERO    = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0] C_ONE     = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_P_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] C_P_ONE  = PTR_W'(1);

  // Each entry holds {instruction, pc, irq, fiq}. The interrupt bits stay
  // with their instruction.
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_overflow;

  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic [ENTRY_W-1:0] w_head;

  // Handshake decode. A data stall blocks pops and also masks the ALU clear.
  // Push uses the current count, so a pop does not free a slot in the same cycle.
  always_comb begin
    w_valid = (r_count != C_ZERO);
    w_pop   = w_valid && !i_stall_from_decode && !i_data_stall &&
              !i_stall_from_shifter && !i_issue_stall;
    w_push  = i_instruction_valid && (r_count < C_FULL);
    w_flush = i_clear_from_writeback || (i_clear_from_alu && !i_data_stall);
  end

  // Pointer, occupancy and overflow state, with reset and flush taking priority.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      r_rd_ptr   <= C_P_ZERO;
      r_wr_ptr   <= C_P_ZERO;
      r_count    <= C_ZERO;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_instruction_valid && (r_count == C_FULL);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_P_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write. The array needs no reset because empty entries are never
  // shown on the outputs.
  always_ff @(posedge i_clk) begin
    if (w_push && !w_flush && !i_reset) begin
      r_mem[r_wr_ptr] <= {i_instruction, i_pc, i_irq, i_fiq};
    end
  end

  // Head read-out is driven only from state. It is forced to zero when the FIFO is empty.
  always_comb begin
    if (w_valid) begin
      w_head = r_mem[r_rd_ptr];
    end else begin
      w_head = {ENTRY_W{1'b0}};
    end
  end

  assign o_instruction       = w_head[ENTRY_W-1 -: 35];
  assign o_pc                = w_head[33:2];
  assign o_irq               = w_head[1];
  assign o_fiq               = w_head[0];
  assign o_instruction_valid = w_valid;
  assign o_fetch_stall       = (r_count >= C_ALMOST);
  assign o_overflow          = r_overflow;

endmodule

// File: tb/tb_zap_fetch_issue_fifo.sv
// Scoreboard bench for zap_fetch_issue_fifo. The driver updates a queue-based
// reference model at every clock edge. A separate monitor compares DUT outputs
// against the model on every falling edge.
module tb_zap_fetch_issue_fifo;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [34:0] i_instruction;
  logic        i_instruction_valid;
  logic [31:0] i_pc;
  logic        i_irq, i_fiq;
  logic        i_stall_from_decode, i_clear_from_writeback, i_data_stall;
  logic        i_clear_from_alu, i_stall_from_shifter, i_issue_stall;
  logic [34:0] o_instruction;
  logic        o_instruction_valid;
  logic [31:0] o_pc;
  logic        o_irq, o_fiq, o_fetch_stall, o_overflow;

  zap_fetch_issue_fifo #(.DEPTH(4), .PTR_W(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_instruction(i_instruction), .i_instruction_valid(i_instruction_valid),
    .i_pc(i_pc), .i_irq(i_irq), .i_fiq(i_fiq),
    .i_stall_from_decode(i_stall_from_decode),
    .i_clear_from_writeback(i_clear_from_writeback),
    .i_data_stall(i_data_stall), .i_clear_from_alu(i_clear_from_alu),
    .i_stall_from_shifter(i_stall_from_shifter), .i_issue_stall(i_issue_stall),
    .o_instruction(o_instruction), .o_instruction_valid(o_instruction_valid),
    .o_pc(o_pc), .o_irq(o_irq), .o_fiq(o_fiq),
    .o_fetch_stall(o_fetch_stall), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [34:0] ins;
    logic [31:0] pc;
    logic        irq;
    logic        fiq;
  } entry_t;

  entry_t model_q[$];
  logic   exp_ovf = 1'b0;
  logic   mon_en  = 1'b0;
  int     checks  = 0;
  int     failures = 0;

  // Reference model: the FIFO is a queue, and a flush empties the queue.
  task automatic model_edge();
    entry_t e;
    bit full;
    e = '{ins: i_instruction, pc: i_pc, irq: i_irq, fiq: i_fiq};
    full = (model_q.size() == 4);
    if (i_reset || i_clear_from_writeback) begin
      model_q.delete();
      exp_ovf = 1'b0;
    end else if (i_data_stall) begin
      exp_ovf = i_instruction_valid && full;
      if (i_instruction_valid && !full) model_q.push_back(e);
    end else if (i_clear_from_alu) begin
      model_q.delete();
      exp_ovf = 1'b0;
    end else begin
      exp_ovf = i_instruction_valid && full;
      if (model_q.size() != 0 && !i_stall_from_decode && !i_stall_from_shifter && !i_issue_stall)
        void'(model_q.pop_front());
      if (i_instruction_valid && !full) model_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    i_reset = 1'b0; i_instruction = 35'd0; i_instruction_valid = 1'b0;
    i_pc = 32'd0; i_irq = 1'b0; i_fiq = 1'b0;
    i_stall_from_decode = 1'b0; i_clear_from_writeback = 1'b0;
    i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
    i_stall_from_shifter = 1'b0; i_issue_stall = 1'b0;
  endtask

  task automatic set_push(input logic [34:0] ins, input logic [31:0] pc,
                          input logic irq, input logic fiq);
    i_instruction_valid = 1'b1; i_instruction = ins; i_pc = pc;
    i_irq = irq; i_fiq = fiq;
  endtask

  // Monitor: compares outputs against the model away from the active edge.
  always @(negedge i_clk) begin
    if (mon_en) begin
      entry_t exp_h, act_h;
      logic   exp_v, exp_fs;
      exp_v  = (model_q.size() != 0);
      exp_h  = exp_v ? model_q[0] : '0;
      exp_fs = (model_q.size() >= 3);
      act_h  = '{ins: o_instruction, pc: o_pc, irq: o_irq, fiq: o_fiq};
      checks += 3;
      if (act_h !== exp_h) begin
        failures++;
        $display("FAIL head t=%0t got ins=%h pc=%h irq=%b fiq=%b want ins=%h pc=%h irq=%b fiq=%b",
                 $time, act_h.ins, act_h.pc, act_h.irq, act_h.fiq,
                 exp_h.ins, exp_h.pc, exp_h.irq, exp_h.fiq);
      end
      if ({o_instruction_valid, o_fetch_stall} !== {exp_v, exp_fs}) begin
        failures++;
        $display("FAIL valid_fstall t=%0t got v=%b fs=%b want v=%b fs=%b",
                 $time, o_instruction_valid, o_fetch_stall, exp_v, exp_fs);
      end
      if (o_overflow !== exp_ovf) begin
        failures++;
        $display("FAIL overflow t=%0t got %b want %b", $time, o_overflow, exp_ovf);
      end
    end
  end

  initial begin
    logic [34:0] held_ins;
    logic [31:0] held_pc;
    idle();
    i_reset = 1'b1;
    tick(); tick();
    idle();

    // The first push appears one cycle later and is then popped.
    set_push(35'h0E1A00000, 32'h100, 1'b1, 1'b0);
    tick(); idle(); tick(); tick();

    // Four back-to-back pushes with no stall.
    for (int i = 0; i < 4; i++) begin
      set_push(35'h0E2800001 + 35'(i), 32'h200 + 32'(4*i), 1'b0, 1'(i[0])); tick();
    end
    idle(); tick(); tick();

    // Sequencer stall with an LDM at the head while the FIFO fills and then overflows.
    i_stall_from_decode = 1'b1;
    set_push(35'h0E8BD000F, 32'h300, 1'b0, 1'b1); tick();
    @(negedge i_clk);
    held_ins = o_instruction; held_pc = o_pc;
    for (int i = 0; i < 5; i++) begin
      set_push(35'h0E3A00000 + 35'(i), 32'h304 + 32'(4*i), 1'(i[0]), 1'b0);
      tick();
      @(negedge i_clk);
      checks++;
      if (o_instruction !== held_ins || o_pc !== held_pc || o_instruction !== 35'h0E8BD000F) begin
        failures++;
        $display("FAIL head_stable i=%0d got %h/%h want %h/%h", i, o_instruction, o_pc, held_ins, held_pc);
      end
    end

    // Full with pop and push together: the push is refused.
    i_stall_from_decode = 1'b0;
    set_push(35'h0AAAA0000, 32'h400, 1'b0, 1'b0); tick();
    // Count of 3 with pop and push together: the pointers wrap past DEPTH.
    for (int i = 0; i < 6; i++) begin
      set_push(35'h0BBBB0000 + 35'(i), 32'h500 + 32'(4*i), 1'b0, 1'b0); tick();
    end

    // Data stall masks the ALU clear. The ALU clear alone then flushes.
    idle(); i_clear_from_alu = 1'b1; tick();
    idle(); set_push(35'h1, 32'h600, 1'b0, 1'b0); tick();
    set_push(35'h2, 32'h604, 1'b0, 1'b0); i_issue_stall = 1'b1; tick();
    idle(); i_data_stall = 1'b1; i_clear_from_alu = 1'b1; tick();
    idle(); i_clear_from_alu = 1'b1; tick();
    idle(); tick();

    // A writeback clear discards a simultaneous push.
    set_push(35'h3, 32'h700, 1'b0, 1'b0); tick();
    set_push(35'h7DEADBEEF, 32'h704, 1'b1, 1'b1); i_clear_from_writeback = 1'b1; tick();
    idle(); tick(); tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      i_instruction_valid    = ($urandom_range(0, 99) < 60);
      i_instruction          = {3'($urandom), 32'($urandom)};
      i_pc                   = $urandom;
      i_irq                  = 1'($urandom);
      i_fiq                  = 1'($urandom);
      i_stall_from_decode    = ($urandom_range(0, 99) < 30);
      i_data_stall           = ($urandom_range(0, 99) < 15);
      i_stall_from_shifter   = ($urandom_range(0, 99) < 10);
      i_issue_stall          = ($urandom_range(0, 99) < 10);
      i_clear_from_alu       = ($urandom_range(0, 99) < 4);
      i_clear_from_writeback = ($urandom_range(0, 99) < 2);
      i_reset                = ($urandom_range(0, 999) < 3);
      tick();
    end
    idle(); tick();
    @(negedge i_clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
